// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: sums CHUNK bits per clock and pulses done with sum, carry-out and overflow.
// Define CHUNKED_ADDER_SATURATE_EN to clamp sum to the signed limit on overflow.
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovfl_q, ovfl_d;

  int                base;
  logic [CHUNK:0]    chunkRes;
  logic              msbCarryIn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovfl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovfl_q  <= ovfl_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovfl_d   = ovfl_q;

    base     = int'(idx_q) * CHUNK;
    chunkRes = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
             + {{CHUNK{1'b0}}, carry_q};
    // The top result bit is a^b^carry-in, so the carry into the MSB falls out by XOR.
    msbCarryIn = chunkRes[CHUNK-1] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1];

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[base +: CHUNK] = chunkRes[CHUNK-1:0];
        carry_d = chunkRes[CHUNK];
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = chunkRes[CHUNK];
          ovfl_d  = msbCarryIn ^ chunkRes[CHUNK];
`ifdef CHUNKED_ADDER_SATURATE_EN
          if (msbCarryIn ^ chunkRes[CHUNK]) begin
            sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end else begin
            sum_d = acc_d;
          end
`else
          sum_d   = acc_d;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovfl = ovfl_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder (WIDTH=16, CHUNK=4): directed vectors, handshake/reset
// sequences and random operations against a plain-arithmetic reference model.
module tb_chunked_adder;

  localparam int W = 16;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst, start, cin, sub;
  logic [W-1:0]  a, b, sum;
  logic          busy, done, cout, ovfl;

  int            tests = 0;
  int            fails = 0;
  logic [W-1:0]  prevSum;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic         vsub;
    logic [W-1:0] rawSum;
    logic [W-1:0] satSum;
    logic         eCout;
    logic         eOvfl;
  } vec_t;

  vec_t vecs[9];

  chunked_adder #(.WIDTH(W), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovfl(ovfl)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: full-width integer add, overflow from operand/result signs.
  function automatic logic [W+1:0] refAdd(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                          input logic rc, input logic rs);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         o;
    bb   = rs ? ~rb : rb;
    full = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, rc};
    s    = full[W-1:0];
    o    = (ra[W-1] == bb[W-1]) && (s[W-1] != ra[W-1]);
`ifdef CHUNKED_ADDER_SATURATE_EN
    if (o) s = ra[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    return {s, full[W], o};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Runs one operation starting at the next negedge and checks every cycle up to done.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc,
                               input logic ts, input logic [W-1:0] eSum, input logic eCout,
                               input logic eOvfl);
    @(negedge clk);
    a = ta; b = tb2; cin = tc; sub = ts; start = 1'b1;
    for (int c = 1; c <= N + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
      checkOutput("busy", {31'b0, busy}, {31'b0, c <= N});
      checkOutput("done", {31'b0, done}, {31'b0, c == N + 1});
      if (c <= N) checkOutput("sumHold", {16'b0, sum}, {16'b0, prevSum});
    end
    checkOutput("sum", {16'b0, sum}, {16'b0, eSum});
    checkOutput("cout", {31'b0, cout}, {31'b0, eCout});
    checkOutput("ovfl", {31'b0, ovfl}, {31'b0, eOvfl});
    prevSum = eSum;
    @(negedge clk);
    checkOutput("doneOnce", {31'b0, done}, 32'd0);
    checkOutput("sumKept", {16'b0, sum}, {16'b0, eSum});
  endtask

  initial begin
    logic [W+1:0] r;
    logic [W-1:0] ra, rb;
    logic         rc, rs;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
    vecs[7] = '{16'h0010, 16'h0010, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    vecs[8] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    checkOutput("rstDone", {31'b0, done}, 32'd0);
    checkOutput("rstSum", {16'b0, sum}, 32'd0);
    checkOutput("rstCout", {31'b0, cout}, 32'd0);
    checkOutput("rstOvfl", {31'b0, ovfl}, 32'd0);
    rst = 1'b0;
    prevSum = '0;

    for (int i = 0; i < 9; i++) begin
`ifdef CHUNKED_ADDER_SATURATE_EN
      applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
                    vecs[i].satSum, vecs[i].eCout, vecs[i].eOvfl);
`else
      applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
                    vecs[i].rawSum, vecs[i].eCout, vecs[i].eOvfl);
`endif
    end

    // Handshake: start during RUN ignored, start during DONE accepted back-to-back.
    @(negedge clk);
    a = 16'h1234; b = 16'h0FFF; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 2) begin
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
      end
      checkOutput("hsBusy", {31'b0, busy}, {31'b0, (c >= 1 && c <= 4) || (c >= 6 && c <= 9)});
      checkOutput("hsDone", {31'b0, done}, {31'b0, c == 5 || c == 10});
      if (c == 5) begin
        checkOutput("hsSum1", {16'b0, sum}, 32'h2233);
        checkOutput("hsCout1", {31'b0, cout}, 32'd0);
        a = 16'h0100; b = 16'h0023; cin = 1'b0; sub = 1'b0; start = 1'b1;
      end
      if (c >= 6 && c <= 9) checkOutput("hsHold", {16'b0, sum}, 32'h2233);
      if (c == 10) checkOutput("hsSum2", {16'b0, sum}, 32'h0123);
    end
    prevSum = 16'h0123;

    // Reset mid-operation: discarded, outputs cleared, new op completes normally.
    @(negedge clk);
    a = 16'h4000; b = 16'h4000; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst = 1'b0;
      if (c == 2) rst = 1'b1;
      if (c == 3) begin
        checkOutput("rmSum", {16'b0, sum}, 32'd0);
        checkOutput("rmCout", {31'b0, cout}, 32'd0);
        checkOutput("rmOvfl", {31'b0, ovfl}, 32'd0);
        a = 16'h1111; b = 16'h2222; start = 1'b1;
      end
      checkOutput("rmBusy", {31'b0, busy}, {31'b0, (c <= 2) || (c >= 4 && c <= 7)});
      checkOutput("rmDone", {31'b0, done}, {31'b0, c == 8});
      if (c >= 4 && c <= 7) checkOutput("rmHold", {16'b0, sum}, 32'd0);
      if (c == 8) begin
        checkOutput("rmSum2", {16'b0, sum}, 32'h3333);
        checkOutput("rmOvfl2", {31'b0, ovfl}, 32'd0);
      end
    end
    prevSum = 16'h3333;

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (i < 4) begin
        ra = (i[0]) ? 16'h8000 : 16'h7FFF;
        rb = (i[0]) ? 16'h8000 : 16'h7FFF;
      end
      r = refAdd(ra, rb, rc, rs);
      applyStimulus(ra, rb, rc, rs, r[W+1:2], r[1], r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
